// File: rtl/dmem_responder.sv
// Data-memory responder: word array with programmable wait states and a one-cycle response strobe.
// Optional access-fault reporting for out-of-range addresses is enabled by defining DMEM_RESP_ERR_EN.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_busy,
  output logic        dmem_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [IDX_W-1:0]   idx_q;
  logic [3:0]         wmask_q;
  logic [31:0]        wdata_q;
  logic               fault_q;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               req;
  logic [31:0]        off;
  logic [IDX_W-1:0]   idx_in;
  logic               fault_in;
  logic               commit;
  logic [IDX_W-1:0]   c_idx;
  logic [3:0]         c_wmask;
  logic [31:0]        c_wdata;
  logic               c_fault;
  logic               unused_off;

  assign req        = |(dmem_rmask | dmem_wmask);
  assign off        = dmem_addr - BASE_ADDR;
  assign idx_in     = off[IDX_W+1:2];
  assign unused_off = ^{off[31:IDX_W+2], off[1:0]};

`ifdef DMEM_RESP_ERR_EN
  assign fault_in = !((dmem_addr >= BASE_ADDR) && (off[31:IDX_W+2] == '0));
`else
  assign fault_in = 1'b0;
`endif

  // With zero wait states the commit happens on the accept edge, so it must use the live request.
  always_comb begin
    commit  = 1'b0;
    c_idx   = idx_q;
    c_wmask = wmask_q;
    c_wdata = wdata_q;
    c_fault = fault_q;
    if (WAIT_STATES == 0) begin
      commit  = (state == S_IDLE) && req;
      c_idx   = idx_in;
      c_wmask = dmem_wmask;
      c_wdata = dmem_wdata;
      c_fault = fault_in;
    end else begin
      commit = (state == S_WAIT) && (cnt == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && commit && !c_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wmask[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      dmem_resp  <= 1'b0;
      dmem_rdata <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      dmem_resp <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            idx_q   <= idx_in;
            wmask_q <= dmem_wmask;
            wdata_q <= dmem_wdata;
            fault_q <= fault_in;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              cnt   <= 4'(WAIT_STATES - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // Read-before-write: the nonblocking read sees the word as it was before this edge's store.
      if (commit) begin
        dmem_resp  <= 1'b1;
        dmem_rdata <= c_fault ? 32'h0 : mem[c_idx];
      end
    end
  end

  assign dmem_busy = (state != S_IDLE);

`ifdef DMEM_RESP_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst)        dmem_err <= 1'b0;
    else if (commit) dmem_err <= c_fault;
    else             dmem_err <= 1'b0;
  end
`else
  assign dmem_err = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the pipeline's data-memory port: accepts the byte-masked load/store request driven by the MEM stage and returns read data with a one-cycle response strobe. It is backed by an on-chip word array and has a programmable number of wait states. The wait states let the stall/hold logic in the pipeline be exercised before a real cache is attached. It sits between the MEM stage and the top level, in place of the cache hierarchy.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the backing array; power of two, at least 4.
- WAIT_STATES, 2: extra cycles between accept and response; legal range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- dmem_addr  in  32  byte address; bits [1:0] are ignored.
- dmem_rmask  in  4  read byte enables; nonzero means a load request.
- dmem_wmask  in  4  write byte enables; nonzero means a store request.
- dmem_wdata  in  32  store data, already lane-positioned by the initiator.
- dmem_rdata  out  32  load data, full word; valid only while dmem_resp is high.
- dmem_resp  out  1  one-cycle response strobe.
- dmem_busy  out  1  high from accept until the end of the response cycle.
- dmem_err  out  1  access fault flag, qualified by dmem_resp (DMEM_RESP_ERR_EN only).

## Operation
- Request present: (dmem_rmask | dmem_wmask) != 0. The initiator holds addr, masks and wdata stable until it sees dmem_resp, then may change them from the next cycle.
- Word index: (dmem_addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- In range: dmem_addr in [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
- FSM states and transitions:
  - IDLE: sample the request. If present, latch addr, rmask, wmask and wdata. Go to RESP if WAIT_STATES == 0; otherwise load the counter with WAIT_STATES-1 and go to WAIT.
  - WAIT: decrement the counter. Leave for RESP on the edge where the counter is 0. Inputs are ignored.
  - RESP: dmem_resp = 1 for exactly one cycle, then go to IDLE. A request still asserted during RESP is the old one and must not be re-accepted.
- Commit happens on the edge entering RESP:
  - dmem_rdata <= array word read before any write (read-before-write).
  - Then each byte lane with wmask[i]=1 is written from wdata[8i+7:8i].
- Read data is the full word regardless of rmask; lane extraction and sign extension belong to WB.
- Both rmask and wmask nonzero is legal: the access returns the old word and writes the new bytes.
- dmem_rdata holds its value outside RESP. Nothing else may rely on it outside the response cycle.
- dmem_busy = (state != IDLE).
- Array contents are not cleared by reset and are undefined at power-up.

## Timing
- Reset values: state IDLE, dmem_resp 0, dmem_rdata 32'h0, dmem_busy 0, dmem_err 0, counter 0.
- Latency: a request present in cycle N has dmem_resp high in cycle N+1+WAIT_STATES.
- Throughput: the earliest next accept is the IDLE cycle following RESP. Back-to-back period is WAIT_STATES+2 cycles.
- Reset asserted in WAIT or RESP:
  - The FSM returns to IDLE on that edge and no response is issued.
  - A store not yet committed (WAIT) is dropped.
  - A store committed on entry to RESP stays written.
- Reset takes priority over every other transition.

## Configuration
- DMEM_RESP_ERR_EN defined:
  - An out-of-range address is latched as a fault at accept.
  - In RESP, dmem_err = 1, dmem_rdata = 32'h0, and the store is suppressed.
  - Latency is unchanged.
- DMEM_RESP_ERR_EN undefined:
  - dmem_err is tied to 0.
  - Out-of-range addresses alias into the array via the truncated word index; reads and writes complete normally.

## Test plan
- Reset then idle (WAIT_STATES=2): hold rst=0 for 2 cycles, then release -> dmem_resp, dmem_busy and dmem_rdata are 0 for 10 idle cycles.
- Word store then load (WAIT_STATES=2):
  - Store addr 0x10, wmask 4'hF, wdata 0xDEADBEEF -> resp exactly 3 cycles after the request cycle.
  - Then load addr 0x10, rmask 4'hF -> rdata 0xDEADBEEF, resp 3 cycles later.
- Byte-lane store: over 0xDEADBEEF, store wmask 4'b0100 with wdata 0x00AA0000 -> a later load returns 0xDEAABEEF.
- Zero wait states and read-before-write:
  - WAIT_STATES=0, request held continuously -> resp in N+1, busy pattern 1,0,1,0…; RESP is never re-accepted.
  - Combined rmask=4'hF, wmask=4'hF, wdata 0x12345678 over 0xCAFEF00D -> rdata 0xCAFEF00D; a following load returns 0x12345678.
- Reset mid-transaction (WAIT_STATES=5): store 0x55555555 to 0x20, pull rst low during WAIT -> no resp; a subsequent load of 0x20 returns the prior contents.
- With DMEM_RESP_ERR_EN: load at BASE_ADDR + 4*DEPTH_WORDS -> resp with dmem_err=1, rdata 0; a store to the same address leaves word 0 unchanged.
